xgmii_burst_tx: RTL and testbench
=================================

XGMII_BURST_TX -- requirements
Module: xgmii_burst_tx

Interface
REQ-001 SHALL have parameter MAX_BURST, default 32: maximum data columns per frame, range 1..255.
REQ-002 SHALL have parameter MIN_IDLE, default 2: idle columns forced after every terminate or error column, range 1..15.
REQ-003 SHALL have parameter STRETCH_WIDTH, default 24: width of the activity LED stretch counter.
REQ-004 SHALL have port clk, input, 1: single clock for all logic.
REQ-005 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port tx_en, input, 1: user transmit enable.
REQ-007 SHALL have port link_up, input, 1: link status from the XAUI controller.
REQ-008 SHALL have port fifo_rd_data, input, 64: first-word-fall-through FIFO head word.
REQ-009 SHALL have port fifo_empty, input, 1: FIFO empty flag.
REQ-010 SHALL have port fifo_rd_en, output, 1: pops the FIFO head word.
REQ-011 SHALL have port xgmii_txd, output, 64: transmit data, lane 0 in bits [7:0].
REQ-012 SHALL have port xgmii_txc, output, 8: per-lane control flags.
REQ-013 SHALL have port frame_count, output, 32: completed frames, saturating.
REQ-014 SHALL have port err_count, output, 16: aborted frames, saturating.
REQ-015 SHALL have port tx_strb, output, 1: one-cycle pulse on each start column.
REQ-016 SHALL have port tx_led, output, 1: stretched activity indicator.

Function
REQ-017 SHALL register xgmii_txd/xgmii_txc, so the column selected in cycle N appears in cycle N+1.
REQ-018 SHALL use these column encodings:
- Idle: all lanes 8'h07, txc 8'hFF.
- Start: lane0 8'hFB, lane1 = seq[7:0], lanes 2..7 8'h00, txc 8'h01.
- Data: fifo_rd_data, txc 8'h00.
- Terminate: lane0 8'hFD, lanes 1..7 8'h07, txc 8'hFF.
- Error: all lanes 8'hFE, txc 8'hFF.
REQ-019 SHALL implement FSM states IDLE, START, DATA, TERM, ABORT and GAP.
REQ-020 SHALL, in IDLE, select the idle column and go to START when tx_en & link_up & !fifo_empty.
REQ-021 SHALL, in START, select the start column, pulse tx_strb, clear word_cnt and go to DATA.
REQ-022 SHALL, in DATA, assert fifo_rd_en combinationally iff !fifo_empty & link_up & word_cnt<MAX_BURST, select the data column and increment word_cnt.
REQ-023 SHALL, in DATA, go to ABORT when link_up=0 (this takes priority), otherwise go to TERM when fifo_rd_en=0.
REQ-024 SHALL, in DATA, go to TERM also when tx_en=0, so a frame in progress ends cleanly and no new frame starts.
REQ-025 SHALL never assert fifo_rd_en while fifo_empty=1 or outside DATA.
REQ-026 SHALL, in TERM, select the terminate column, increment frame_count, increment seq (wrapping 255 to 0) and go to GAP.
REQ-027 SHALL, in ABORT, select the error column, increment err_count, leave seq unchanged and go to GAP.
REQ-028 SHALL, in GAP, select MIN_IDLE idle columns via gap_cnt, then go to IDLE.
REQ-029 SHALL hold frame_count at 32'hFFFFFFFF and err_count at 16'hFFFF once reached.
REQ-030 SHALL make the maximum frame exactly MAX_BURST data columns; a FIFO holding 2*MAX_BURST words yields two back-to-back frames separated by MIN_IDLE idles.
REQ-031 SHALL, when link_up=0 in START, still select the start column and then go to ABORT with zero data columns.
REQ-032 SHALL load the LED counter with all-ones on tx_strb only when the counter is zero, otherwise decrement it; tx_led = (counter != 0).

Reset
REQ-033 SHALL, while reset_n=0, force:
- state IDLE.
- xgmii_txd 64'h0707070707070707, xgmii_txc 8'hFF.
- fifo_rd_en 0, tx_strb 0, tx_led 0.
- frame_count 0, err_count 0, seq 0, word_cnt 0, gap_cnt 0, LED counter 0.
REQ-034 SHALL, on reset_n assertion mid-frame, abandon the frame immediately with no terminate or error column emitted.
REQ-035 SHALL, on the first clk edge after reset_n release, evaluate the IDLE entry condition.

Structure
REQ-036 SHALL place in shared package xgmii_pkg: XGMII_IDLE 8'h07, XGMII_START 8'hFB, XGMII_TERM 8'hFD, XGMII_ERROR 8'hFE, and the FSM state typedef.
REQ-037 SHALL implement the LED stretcher as sub-module activity_stretch, parameter STRETCH_WIDTH; ports clk, reset_n, strb, led.

Verification
REQ-038 SHALL cover: FIFO with 3 words, tx_en=1, link_up=1 -> start(seq 0), 3 data columns in order, terminate, 2 idles; frame_count=1.
REQ-039 SHALL cover: 40 words, MAX_BURST=32 -> frame of 32 data (seq 0), terminate, 2 idles, frame of 8 data (seq 1); fifo_rd_en asserted exactly 40 cycles.
REQ-040 SHALL cover: link_up dropped after 5th data column -> next column all 8'hFE, err_count=1, seq unchanged, no fifo_rd_en while link_up=0.
REQ-041 SHALL cover: tx_en deasserted mid-frame -> terminate next, then idle indefinitely with FIFO non-empty.
REQ-042 SHALL cover: reset_n pulsed low mid-frame -> idle column and all counters 0 in the same cycle (asynchronous), restart cleanly.
REQ-043 SHALL cover: 256 single-word frames -> seq wraps to 0; with STRETCH_WIDTH=4, tx_led high for 15 cycles per retrigger.

Source files
------------

// File: rtl/xgmii_pkg.sv
// xgmii_pkg: XGMII control characters and the burst transmitter FSM state type
package xgmii_pkg;
  localparam logic [7:0] XGMII_IDLE  = 8'h07;
  localparam logic [7:0] XGMII_START = 8'hFB;
  localparam logic [7:0] XGMII_TERM  = 8'hFD;
  localparam logic [7:0] XGMII_ERROR = 8'hFE;
  typedef enum logic [2:0] {IDLE, START, DATA, TERM, ABORT, GAP} state_t;
endpackage

// File: rtl/activity_stretch.sv
// activity_stretch: stretches single-cycle strobes into a visible LED pulse
// Ports: clk, reset_n (async, active-low), strb (trigger pulse), led (counter != 0)
module activity_stretch #(
  parameter int STRETCH_WIDTH = 24
) (
  input  logic clk,
  input  logic reset_n,
  input  logic strb,
  output logic led
);
  localparam logic [STRETCH_WIDTH-1:0] ONE = 1;
  logic [STRETCH_WIDTH-1:0] cnt_q, cnt_d;
  // Retrigger only from zero, so every pulse lasts exactly 2^W-1 cycles
  assign cnt_d = (strb && cnt_q == '0) ? '1 : (cnt_q != '0) ? cnt_q - ONE : cnt_q;
  assign led = cnt_q != '0;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/xgmii_burst_tx.sv
// xgmii_burst_tx: drains a FWFT FIFO into framed XGMII bursts (start/data/terminate/idle)
// Ports: clk, reset_n (async, active-low); tx_en, link_up gate frame starts;
//   fifo_rd_data/fifo_empty/fifo_rd_en form the FIFO pop interface;
//   xgmii_txd/xgmii_txc are the registered XGMII column; frame_count/err_count
//   are saturating statistics; tx_strb pulses with each start column; tx_led is stretched activity.
module xgmii_burst_tx
  import xgmii_pkg::*;
#(
  parameter int MAX_BURST     = 32,
  parameter int MIN_IDLE      = 2,
  parameter int STRETCH_WIDTH = 24
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        tx_en,
  input  logic        link_up,
  input  logic [63:0] fifo_rd_data,
  input  logic        fifo_empty,
  output logic        fifo_rd_en,
  output logic [63:0] xgmii_txd,
  output logic [7:0]  xgmii_txc,
  output logic [31:0] frame_count,
  output logic [15:0] err_count,
  output logic        tx_strb,
  output logic        tx_led
);
  localparam logic [7:0]  MAX_W    = 8'(MAX_BURST);
  localparam logic [3:0]  GAP_LAST = 4'(MIN_IDLE - 1);
  localparam logic [63:0] IDLE_COL = {8{XGMII_IDLE}};
  state_t      state_q, state_d, cur;
  logic [7:0]  seq_q, seq_d, word_cnt_q, word_cnt_d;
  logic [3:0]  gap_cnt_q, gap_cnt_d;
  logic [31:0] frame_q, frame_d;
  logic [15:0] err_q, err_d;
  logic [63:0] txd_q, txd_d;
  logic [7:0]  txc_q, txc_d;
  logic        strb_q, strb_d, start_ok;
  assign start_ok   = tx_en && link_up && !fifo_empty;
  assign fifo_rd_en = (state_q == DATA) && !fifo_empty && link_up && (word_cnt_q < MAX_W);
  // A DATA cycle with nothing to pop behaves as TERM/ABORT in that same cycle,
  // so the closing column follows the last data column with no hole.
  assign cur = (state_q == DATA && !fifo_rd_en) ? (link_up ? TERM : ABORT) : state_q;
  always_comb begin
    state_d    = cur;
    txd_d      = IDLE_COL;
    txc_d      = 8'hFF;
    strb_d     = 1'b0;
    seq_d      = seq_q;
    word_cnt_d = word_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    frame_d    = frame_q;
    err_d      = err_q;
    case (cur)
      IDLE: state_d = start_ok ? START : IDLE;
      START: begin
        txd_d      = {48'h0, seq_q, XGMII_START};
        txc_d      = 8'h01;
        strb_d     = 1'b1;
        word_cnt_d = '0;
        state_d    = link_up ? DATA : ABORT;
      end
      DATA: begin
        txd_d      = fifo_rd_data;
        txc_d      = 8'h00;
        word_cnt_d = word_cnt_q + 8'd1;
        state_d    = tx_en ? DATA : TERM;
      end
      TERM: begin
        txd_d     = {{7{XGMII_IDLE}}, XGMII_TERM};
        frame_d   = (frame_q == '1) ? frame_q : frame_q + 32'd1;
        seq_d     = seq_q + 8'd1;
        gap_cnt_d = '0;
        state_d   = GAP;
      end
      ABORT: begin
        txd_d     = {8{XGMII_ERROR}};
        err_d     = (err_q == '1) ? err_q : err_q + 16'd1;
        gap_cnt_d = '0;
        state_d   = GAP;
      end
      GAP: begin
        gap_cnt_d = gap_cnt_q + 4'd1;
        // The last gap cycle also evaluates the start condition, keeping
        // back-to-back frames exactly MIN_IDLE idle columns apart.
        state_d   = (gap_cnt_q != GAP_LAST) ? GAP : start_ok ? START : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q    <= IDLE;
      seq_q      <= '0;
      word_cnt_q <= '0;
      gap_cnt_q  <= '0;
      frame_q    <= '0;
      err_q      <= '0;
      txd_q      <= IDLE_COL;
      txc_q      <= 8'hFF;
      strb_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      seq_q      <= seq_d;
      word_cnt_q <= word_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      frame_q    <= frame_d;
      err_q      <= err_d;
      txd_q      <= txd_d;
      txc_q      <= txc_d;
      strb_q     <= strb_d;
    end
  assign xgmii_txd   = txd_q;
  assign xgmii_txc   = txc_q;
  assign frame_count = frame_q;
  assign err_count   = err_q;
  assign tx_strb     = strb_q;
  activity_stretch #(.STRETCH_WIDTH(STRETCH_WIDTH)) u_led (
    .clk    (clk),
    .reset_n(reset_n),
    .strb   (strb_q),
    .led    (tx_led)
  );
endmodule

// File: tb/tb_xgmii_burst_tx.sv
// tb_xgmii_burst_tx: directed self-checking bench for xgmii_burst_tx with a FWFT FIFO model
module tb_xgmii_burst_tx;
  localparam logic [63:0] IDLE_COL = 64'h0707070707070707;
  localparam logic [63:0] TERM_COL = 64'h07070707070707FD;
  localparam logic [63:0] ERR_COL  = 64'hFEFEFEFEFEFEFEFE;
  logic        clk = 1'b0, reset_n = 1'b0, tx_en = 1'b0, link_up = 1'b0, fifo_empty = 1'b1;
  logic [63:0] fifo_rd_data = '0;
  logic        fifo_rd_en, tx_strb, tx_led;
  logic [63:0] xgmii_txd;
  logic [7:0]  xgmii_txc;
  logic [31:0] frame_count;
  logic [15:0] err_count;
  int checks = 0, errors = 0;
  logic [63:0] fq[$];
  logic [63:0] s_txd;
  logic [7:0]  s_txc;
  logic        s_rd, s_strb, s_led;
  int rd_total = 0, rd_bad = 0, led_run = 0, run_min = 1000, run_max = 0, run_n = 0;
  bit run_valid = 0;
  logic [7:0] exp_seq = 8'd0;
  int exp_frames = 0, exp_err = 0;
  always #5 clk = ~clk;
  xgmii_burst_tx #(.MAX_BURST(32), .MIN_IDLE(2), .STRETCH_WIDTH(4)) dut (
    .clk(clk), .reset_n(reset_n), .tx_en(tx_en), .link_up(link_up),
    .fifo_rd_data(fifo_rd_data), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
    .xgmii_txd(xgmii_txd), .xgmii_txc(xgmii_txc), .frame_count(frame_count),
    .err_count(err_count), .tx_strb(tx_strb), .tx_led(tx_led)
  );
  task automatic fifo_sync();
    fifo_empty   = (fq.size() == 0);
    fifo_rd_data = fifo_empty ? 64'h0 : fq[0];
  endtask
  task automatic push(input logic [63:0] w);
    fq.push_back(w);
    fifo_sync();
  endtask
  // Sample outputs at the falling edge, then pop the FIFO model just after the rising edge.
  task automatic tick();
    @(negedge clk);
    s_txd = xgmii_txd; s_txc = xgmii_txc; s_rd = fifo_rd_en; s_strb = tx_strb; s_led = tx_led;
    if (s_rd) begin
      rd_total++;
      if (fifo_empty || !link_up) rd_bad++;
    end
    if (s_led) led_run++;
    else begin
      if (run_valid && led_run > 0) begin
        run_n++;
        if (led_run < run_min) run_min = led_run;
        if (led_run > run_max) run_max = led_run;
      end
      run_valid = 1;
      led_run = 0;
    end
    @(posedge clk); #1;
    if (s_rd && fq.size() > 0) begin
      fq.delete(0);
      fifo_sync();
    end
  endtask
  task automatic wait_start(output bit ok);
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (s_txc == 8'h01 && s_txd[7:0] == 8'hFB) begin
        ok = 1;
        break;
      end
    end
  endtask
  task automatic test_reset();
    tick(); tick();
    checks++; if ({s_txc, s_txd} !== {8'hFF, IDLE_COL}) begin errors++; $display("FAIL reset_col: got %h want %h", {s_txc, s_txd}, {8'hFF, IDLE_COL}); end
    checks++; if ({s_rd, s_strb, s_led} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b want 000", {s_rd, s_strb, s_led}); end
    checks++; if ({frame_count, err_count} !== 48'h0) begin errors++; $display("FAIL reset_counts: got %h want 0", {frame_count, err_count}); end
    reset_n = 1'b1;
    tick();
  endtask
  task automatic test_single_frame();
    logic [63:0] w [3] = '{64'h0123456789ABCDEF, 64'hFEDCBA9876543210, 64'h00000000FFFFFFFF};
    bit ok;
    for (int i = 0; i < 3; i++) push(w[i]);
    rd_total = 0; tx_en = 1'b1; link_up = 1'b1;
    wait_start(ok);
    checks++; if (!ok || {s_txc, s_txd} !== {8'h01, 48'h0, exp_seq, 8'hFB}) begin errors++; $display("FAIL basic_start: got %h want %h", {s_txc, s_txd}, {8'h01, 48'h0, exp_seq, 8'hFB}); end
    checks++; if (s_strb !== 1'b1) begin errors++; $display("FAIL basic_strb: got %b want 1", s_strb); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if ({s_txc, s_txd} !== {8'h00, w[i]}) begin errors++; $display("FAIL basic_data%0d: got %h want %h", i, {s_txc, s_txd}, {8'h00, w[i]}); end
    end
    tick();
    checks++; if ({s_txc, s_txd} !== {8'hFF, TERM_COL}) begin errors++; $display("FAIL basic_term: got %h want %h", {s_txc, s_txd}, {8'hFF, TERM_COL}); end
    exp_frames++; exp_seq++;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if ({s_txc, s_txd} !== {8'hFF, IDLE_COL}) begin errors++; $display("FAIL basic_idle%0d: got %h want %h", i, {s_txc, s_txd}, {8'hFF, IDLE_COL}); end
    end
    checks++; if (frame_count !== 32'(exp_frames)) begin errors++; $display("FAIL basic_frames: got %0d want %0d", frame_count, exp_frames); end
    checks++; if (rd_total != 3) begin errors++; $display("FAIL basic_rd: got %0d want 3", rd_total); end
  endtask
  task automatic test_back_to_back();
    bit ok;
    for (int i = 0; i < 40; i++) push(64'hB0B0000000000000 + 64'(i));
    rd_total = 0;
    wait_start(ok);
    checks++; if (!ok || {s_txc, s_txd} !== {8'h01, 48'h0, exp_seq, 8'hFB}) begin errors++; $display("FAIL b2b_start0: got %h want %h", {s_txc, s_txd}, {8'h01, 48'h0, exp_seq, 8'hFB}); end
    for (int i = 0; i < 32; i++) begin
      tick();
      checks++; if ({s_txc, s_txd} !== {8'h00, 64'hB0B0000000000000 + 64'(i)}) begin errors++; $display("FAIL b2b_data%0d: got %h want %h", i, {s_txc, s_txd}, {8'h00, 64'hB0B0000000000000 + 64'(i)}); end
    end
    tick();
    checks++; if ({s_txc, s_txd} !== {8'hFF, TERM_COL}) begin errors++; $display("FAIL b2b_term0: got %h want %h", {s_txc, s_txd}, {8'hFF, TERM_COL}); end
    exp_frames++; exp_seq++;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if ({s_txc, s_txd} !== {8'hFF, IDLE_COL}) begin errors++; $display("FAIL b2b_gap%0d: got %h want %h", i, {s_txc, s_txd}, {8'hFF, IDLE_COL}); end
    end
    tick();
    checks++; if ({s_txc, s_txd} !== {8'h01, 48'h0, exp_seq, 8'hFB}) begin errors++; $display("FAIL b2b_start1: got %h want %h", {s_txc, s_txd}, {8'h01, 48'h0, exp_seq, 8'hFB}); end
    for (int i = 32; i < 40; i++) begin
      tick();
      checks++; if ({s_txc, s_txd} !== {8'h00, 64'hB0B0000000000000 + 64'(i)}) begin errors++; $display("FAIL b2b_data%0d: got %h want %h", i, {s_txc, s_txd}, {8'h00, 64'hB0B0000000000000 + 64'(i)}); end
    end
    tick();
    checks++; if ({s_txc, s_txd} !== {8'hFF, TERM_COL}) begin errors++; $display("FAIL b2b_term1: got %h want %h", {s_txc, s_txd}, {8'hFF, TERM_COL}); end
    exp_frames++; exp_seq++;
    checks++; if (rd_total != 40) begin errors++; $display("FAIL b2b_rd: got %0d want 40", rd_total); end
    checks++; if (frame_count !== 32'(exp_frames)) begin errors++; $display("FAIL b2b_frames: got %0d want %0d", frame_count, exp_frames); end
  endtask
  task automatic test_link_drop();
    bit ok;
    for (int i = 0; i < 10; i++) push(64'hC0C0000000000000 + 64'(i));
    rd_bad = 0;
    wait_start(ok);
    checks++; if (!ok || {s_txc, s_txd} !== {8'h01, 48'h0, exp_seq, 8'hFB}) begin errors++; $display("FAIL drop_start: got %h want %h", {s_txc, s_txd}, {8'h01, 48'h0, exp_seq, 8'hFB}); end
    for (int i = 0; i < 5; i++) begin
      if (i == 4) link_up = 1'b0;
      tick();
      checks++; if ({s_txc, s_txd} !== {8'h00, 64'hC0C0000000000000 + 64'(i)}) begin errors++; $display("FAIL drop_data%0d: got %h want %h", i, {s_txc, s_txd}, {8'h00, 64'hC0C0000000000000 + 64'(i)}); end
    end
    tick();
    checks++; if ({s_txc, s_txd} !== {8'hFF, ERR_COL}) begin errors++; $display("FAIL drop_err: got %h want %h", {s_txc, s_txd}, {8'hFF, ERR_COL}); end
    exp_err++;
    checks++; if (err_count !== 16'(exp_err)) begin errors++; $display("FAIL drop_errcnt: got %0d want %0d", err_count, exp_err); end
    checks++; if (frame_count !== 32'(exp_frames)) begin errors++; $display("FAIL drop_frames: got %0d want %0d", frame_count, exp_frames); end
    for (int i = 0; i < 6; i++) tick();
    checks++; if ({s_txc, s_txd} !== {8'hFF, IDLE_COL}) begin errors++; $display("FAIL drop_idle: got %h want %h", {s_txc, s_txd}, {8'hFF, IDLE_COL}); end
    checks++; if (rd_bad != 0) begin errors++; $display("FAIL drop_rd_bad: got %0d want 0", rd_bad); end
    link_up = 1'b1;
    wait_start(ok);
    checks++; if (!ok || {s_txc, s_txd} !== {8'h01, 48'h0, exp_seq, 8'hFB}) begin errors++; $display("FAIL drop_seq_kept: got %h want %h", {s_txc, s_txd}, {8'h01, 48'h0, exp_seq, 8'hFB}); end
    for (int i = 5; i < 10; i++) begin
      tick();
      checks++; if ({s_txc, s_txd} !== {8'h00, 64'hC0C0000000000000 + 64'(i)}) begin errors++; $display("FAIL drop_rest%0d: got %h want %h", i, {s_txc, s_txd}, {8'h00, 64'hC0C0000000000000 + 64'(i)}); end
    end
    tick();
    checks++; if ({s_txc, s_txd} !== {8'hFF, TERM_COL}) begin errors++; $display("FAIL drop_term: got %h want %h", {s_txc, s_txd}, {8'hFF, TERM_COL}); end
    exp_frames++; exp_seq++;
  endtask
  task automatic test_start_abort();
    bit ok;
    tx_en = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    push(64'hD0D0D0D0D0D0D0D0);
    tx_en = 1'b1;
    tick();
    link_up = 1'b0;
    wait_start(ok);
    checks++; if (!ok || {s_txc, s_txd} !== {8'h01, 48'h0, exp_seq, 8'hFB}) begin errors++; $display("FAIL sabort_start: got %h want %h", {s_txc, s_txd}, {8'h01, 48'h0, exp_seq, 8'hFB}); end
    tick();
    checks++; if ({s_txc, s_txd} !== {8'hFF, ERR_COL}) begin errors++; $display("FAIL sabort_err: got %h want %h", {s_txc, s_txd}, {8'hFF, ERR_COL}); end
    exp_err++;
    checks++; if (err_count !== 16'(exp_err)) begin errors++; $display("FAIL sabort_errcnt: got %0d want %0d", err_count, exp_err); end
    checks++; if (fq.size() != 1) begin errors++; $display("FAIL sabort_fifo: got %0d words want 1", fq.size()); end
  endtask
  task automatic test_tx_en_drop();
    bit ok;
    int starts = 0;
    tx_en = 1'b0;
    link_up = 1'b1;
    for (int i = 1; i < 10; i++) push(64'hE0E0000000000000 + 64'(i));
    for (int i = 0; i < 4; i++) tick();
    rd_total = 0;
    tx_en = 1'b1;
    wait_start(ok);
    checks++; if (!ok || {s_txc, s_txd} !== {8'h01, 48'h0, exp_seq, 8'hFB}) begin errors++; $display("FAIL txen_start: got %h want %h", {s_txc, s_txd}, {8'h01, 48'h0, exp_seq, 8'hFB}); end
    tick();
    checks++; if ({s_txc, s_txd} !== {8'h00, 64'hD0D0D0D0D0D0D0D0}) begin errors++; $display("FAIL txen_data0: got %h want %h", {s_txc, s_txd}, {8'h00, 64'hD0D0D0D0D0D0D0D0}); end
    for (int i = 1; i < 4; i++) begin
      tick();
      if (i == 1) tx_en = 1'b0;
      checks++; if ({s_txc, s_txd} !== {8'h00, 64'hE0E0000000000000 + 64'(i)}) begin errors++; $display("FAIL txen_data%0d: got %h want %h", i, {s_txc, s_txd}, {8'h00, 64'hE0E0000000000000 + 64'(i)}); end
    end
    tick();
    checks++; if ({s_txc, s_txd} !== {8'hFF, TERM_COL}) begin errors++; $display("FAIL txen_term: got %h want %h", {s_txc, s_txd}, {8'hFF, TERM_COL}); end
    exp_frames++; exp_seq++;
    for (int i = 0; i < 20; i++) begin
      tick();
      if ({s_txc, s_txd} !== {8'hFF, IDLE_COL}) starts++;
    end
    checks++; if (starts != 0) begin errors++; $display("FAIL txen_idle: got %0d non-idle columns want 0", starts); end
    checks++; if (rd_total != 4 || fq.size() != 6) begin errors++; $display("FAIL txen_pops: got %0d pops %0d left want 4 pops 6 left", rd_total, fq.size()); end
  endtask
  task automatic test_reset_mid_frame();
    bit ok;
    tx_en = 1'b1;
    wait_start(ok);
    checks++; if (!ok || {s_txc, s_txd} !== {8'h01, 48'h0, exp_seq, 8'hFB}) begin errors++; $display("FAIL rst_start: got %h want %h", {s_txc, s_txd}, {8'h01, 48'h0, exp_seq, 8'hFB}); end
    tick(); tick();
    #2 reset_n = 1'b0;
    #1;
    checks++; if ({xgmii_txc, xgmii_txd} !== {8'hFF, IDLE_COL}) begin errors++; $display("FAIL rst_async_col: got %h want %h", {xgmii_txc, xgmii_txd}, {8'hFF, IDLE_COL}); end
    checks++; if ({frame_count, err_count} !== 48'h0) begin errors++; $display("FAIL rst_async_counts: got %h want 0", {frame_count, err_count}); end
    checks++; if ({fifo_rd_en, tx_strb, tx_led} !== 3'b000) begin errors++; $display("FAIL rst_async_flags: got %b want 000", {fifo_rd_en, tx_strb, tx_led}); end
    tick();
    reset_n = 1'b1;
    exp_frames = 0; exp_err = 0; exp_seq = 8'd0;
    wait_start(ok);
    checks++; if (!ok || {s_txc, s_txd} !== {8'h01, 48'h0, 8'h00, 8'hFB}) begin errors++; $display("FAIL rst_restart: got %h want %h", {s_txc, s_txd}, {8'h01, 56'h0, 8'hFB}); end
    for (int i = 7; i < 10; i++) begin
      tick();
      checks++; if ({s_txc, s_txd} !== {8'h00, 64'hE0E0000000000000 + 64'(i)}) begin errors++; $display("FAIL rst_data%0d: got %h want %h", i, {s_txc, s_txd}, {8'h00, 64'hE0E0000000000000 + 64'(i)}); end
    end
    tick();
    checks++; if ({s_txc, s_txd} !== {8'hFF, TERM_COL}) begin errors++; $display("FAIL rst_term: got %h want %h", {s_txc, s_txd}, {8'hFF, TERM_COL}); end
    exp_frames++; exp_seq++;
    checks++; if (frame_count !== 32'(exp_frames)) begin errors++; $display("FAIL rst_frames: got %0d want %0d", frame_count, exp_frames); end
  endtask
  task automatic test_seq_wrap_led();
    bit ok;
    run_valid = 0; led_run = 0; run_n = 0; run_min = 1000; run_max = 0;
    for (int f = 0; f < 256; f++) begin
      push(64'hF000000000000000 + 64'(f));
      wait_start(ok);
      checks++; if (!ok || {s_txc, s_txd} !== {8'h01, 48'h0, exp_seq, 8'hFB}) begin errors++; $display("FAIL wrap_seq%0d: got %h want %h", f, {s_txc, s_txd}, {8'h01, 48'h0, exp_seq, 8'hFB}); end
      tick();
      tick();
      exp_seq++; exp_frames++;
    end
    checks++; if ({s_txc, s_txd} !== {8'hFF, TERM_COL}) begin errors++; $display("FAIL wrap_term: got %h want %h", {s_txc, s_txd}, {8'hFF, TERM_COL}); end
    for (int i = 0; i < 25; i++) tick();
    checks++; if (frame_count !== 32'(exp_frames)) begin errors++; $display("FAIL wrap_frames: got %0d want %0d", frame_count, exp_frames); end
    checks++; if (run_n < 50 || run_min != 15 || run_max != 15) begin errors++; $display("FAIL led_stretch: got %0d runs len %0d..%0d want >=50 runs len 15", run_n, run_min, run_max); end
  endtask
  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_link_drop();
    test_start_abort();
    test_tx_en_drop();
    test_reset_mid_frame();
    test_seq_wrap_led();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
